data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-port, byte-addressed, big-endian 128-byte data memory between the CPU load/store path (requester 0) and a DMA/loader port (requester 1). It sits between the requesters and the data memory. It sequences each word access through a three-state handshake and rejects accesses that would run past the top of the array.

Parameters:
ADDR_WIDTH, 7, byte-address width of the data memory
DATA_WIDTH, 32, word width; the memory stores 4 bytes per word, big-endian
MEM_BYTES, 128, memory size in bytes; the last legal word address is MEM_BYTES-4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request; held high until ack0
we0  input  1  requester 0 write enable (1=store, 0=load)
addr0  input  ADDR_WIDTH  requester 0 byte address of the MSB byte
wdata0  input  DATA_WIDTH  requester 0 store data
ack0  output  1  one-cycle pulse: requester 0 access complete
err0  output  1  valid with ack0: address out of range, no access made
rdata0  output  DATA_WIDTH  requester 0 load data, registered, valid from ack0 until the next ack0
req1, we1, addr1, wdata1, ack1, err1, rdata1  same as above for requester 1
mem_we  output  1  to data memory write enable
mem_addr  output  ADDR_WIDTH  to data memory address
mem_data  output  DATA_WIDTH  to data memory write data
mem_q  input  DATA_WIDTH  from data memory, combinational read data

Behaviour:
- One clock domain on clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, last=1 (requester 0 wins the first tie), sel=0.
  - ack0/1=0, err0/1=0, rdata0/1=0.
  - mem_we=0, mem_addr=0, mem_data=0.
- FSM states are IDLE, SERVE and DONE.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one request: sel := that requester, go to SERVE.
  - Both requests: sel := !last, go to SERVE.
- SERVE (exactly one cycle):
  - mem_addr and mem_data are driven combinationally from the sel requester.
  - mem_we = we_sel and in_range, where in_range = (addr_sel <= MEM_BYTES-4).
  - The write commits on the rising edge that ends SERVE.
  - On that same edge: rdata_sel := mem_q if load and in_range; else rdata_sel := 0 for an out-of-range load; rdata unchanged for a store.
  - On that same edge: err_sel := !in_range, ack_sel := 1, last := sel.
  - Go to DONE.
- DONE (exactly one cycle):
  - ack_sel=1 and err_sel is valid; the other requester's ack and err are 0.
  - The requester drops req or presents a new transaction in this cycle.
  - The arbiter ignores both req lines in DONE.
  - Go to IDLE. ack and err clear on the edge ending DONE.
- Outside SERVE, mem_we=0, mem_addr=0 and mem_data=0.
- Latency: req sampled high in IDLE at edge N gives ack high during cycle N+2. Minimum period per access is 3 cycles.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1…; neither requester waits more than one access.
- Requester inputs must stay stable from req rise until ack. Changes in IDLE before the grant are legal. Changes during SERVE are undefined.
- Request dropped before grant (in IDLE): it is simply not served and no ack is given.
- Addresses MEM_BYTES-3..MEM_BYTES-1 (125..127): no memory write, err=1, ack=1. This guards addr+1..addr+3 overflow in the memory.
- Unaligned in-range addresses (e.g. 5) are legal; bytes 5..8 are accessed big-endian.
- Reset asserted mid-SERVE: mem_we drops immediately and no write commits unless the commit edge has already passed. All registers return to reset values.
- Reset released: the first edge with rst low may already sample requests.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SERVE=2'd1, DONE=2'd2) and MEM_BYTES/ADDR_WIDTH constants, shared with the data memory.
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker (inputs req0, req1, last; output sel, any).
- The FSM and datapath muxing stay in the top module.

Test Plan:
- Write then read, requester 0: req0, we0=1, addr0=8, wdata0=0xDEADBEEF, then a load from addr 8 → ack0 two cycles after each grant; rdata0=0xDEADBEEF; byte 8=0xDE, byte 11=0xEF.
- Simultaneous requests after reset: req0=req1=1 held for 4 accesses → grant order 0,1,0,1; each ack separated by 3 cycles; ack0 and ack1 are never high together.
- Out of range: req1, we1=1, addr1=125, wdata1=0x11223344 → ack1=1, err1=1, mem_we never high. A following load from 124 returns the prior content, unchanged.
- Unaligned: store 0xA1B2C3D4 at addr 5, then load from addr 4 → rdata=0x??A1B2C3, where the top byte is the previous byte 4.
- Reset mid-SERVE: rst pulsed during a SERVE of a store to addr 0 with 0xFFFFFFFF → mem_we falls asynchronously; addr 0 keeps its old value; all outputs go to 0; the next access behaves normally.
- Single requester back-to-back: req0 held high for 3 loads → acks at cycles 2, 5 and 8 after the first sample; requester 1 idle, so ack1 stays 0.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants and FSM encoding for the data memory arbiter and the data memory.
package data_memory_arbiter_pkg;

   localparam int unsigned ADDR_WIDTH = 7;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned MEM_BYTES  = 128;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StServe = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic sel,
   output logic any
);

   assign any = req0 | req1;
   assign sel = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port big-endian data memory between the CPU (0)
// and the DMA/loader port (1); each access runs IDLE -> SERVE -> DONE.
module data_memory_arbiter #(
   parameter int unsigned ADDR_WIDTH = data_memory_arbiter_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = data_memory_arbiter_pkg::DATA_WIDTH,
   parameter int unsigned MEM_BYTES  = data_memory_arbiter_pkg::MEM_BYTES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic                  err0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic                  err1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   import data_memory_arbiter_pkg::*;

   state_e                state_q, state_d;
   logic                  sel_q, sel_d;
   logic                  last_q, last_d;
   logic                  ack0_q, ack0_d, ack1_q, ack1_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic                  pick_sel, pick_any;
   logic                  we_sel, in_range;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] wdata_sel;

   rr_pick2 u_pick (
      .req0 (req0),
      .req1 (req1),
      .last (last_q),
      .sel  (pick_sel),
      .any  (pick_any)
   );

   assign we_sel    = sel_q ? we1    : we0;
   assign addr_sel  = sel_q ? addr1  : addr0;
   assign wdata_sel = sel_q ? wdata1 : wdata0;
   // The memory reads addr..addr+3, so the last three bytes cannot start a word.
   assign in_range  = 32'(addr_sel) <= (MEM_BYTES - 32'd4);

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      if (state_q == StServe) begin
         mem_we   = we_sel & in_range;
         mem_addr = addr_sel;
         mem_data = wdata_sel;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      last_d   = last_q;
      ack0_d   = ack0_q;
      ack1_d   = ack1_q;
      err0_d   = err0_q;
      err1_d   = err1_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               sel_d   = pick_sel;
               state_d = StServe;
            end
         end
         StServe: begin
            last_d  = sel_q;
            state_d = StDone;
            if (sel_q) begin
               ack1_d = 1'b1;
               err1_d = ~in_range;
               if (!we_sel) rdata1_d = in_range ? mem_q : '0;
            end else begin
               ack0_d = 1'b1;
               err0_d = ~in_range;
               if (!we_sel) rdata0_d = in_range ? mem_q : '0;
            end
         end
         StDone: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            err0_d  = 1'b0;
            err1_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a 128-byte big-endian memory model (byte i = i).
module tb_data_memory_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, we0, ack0, err0;
   logic [6:0]  addr0;
   logic [31:0] wdata0, rdata0;
   logic        req1, we1, ack1, err1;
   logic [6:0]  addr1;
   logic [31:0] wdata1, rdata1;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [31:0] mem_data, mem_q;

   logic [7:0]  mem [128];
   logic        mem_loaded = 1'b0;
   logic        mon_en;
   int          checks;
   int          errors;

   data_memory_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .ack0     (ack0),
      .err0     (err0),
      .rdata0   (rdata0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .ack1     (ack1),
      .err1     (err1),
      .rdata1   (rdata1),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_q    (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_q = {mem[mem_addr], mem[7'(mem_addr + 7'd1)],
                   mem[7'(mem_addr + 7'd2)], mem[7'(mem_addr + 7'd3)]};

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
         mem_loaded <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr]               <= mem_data[31:24];
         mem[7'(mem_addr + 7'd1)]    <= mem_data[23:16];
         mem[7'(mem_addr + 7'd2)]    <= mem_data[15:8];
         mem[7'(mem_addr + 7'd3)]    <= mem_data[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (mon_en) check("ack_excl", 32'(ack0 & ack1), 32'd0);

   // Starts at a negedge in IDLE, returns at a negedge in IDLE after the access completes.
   task automatic access(input int r, input logic we, input logic [6:0] a, input logic [31:0] d,
                         output int lat, output logic err, output logic saw_we);
      lat = 0;
      err = 1'b0;
      saw_we = 1'b0;
      if (r == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         if (mem_we) saw_we = 1'b1;
         if ((r == 0) ? ack0 : ack1) begin
            err = (r == 0) ? err0 : err1;
            break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
   endtask

   int          lat;
   logic        err, swe;
   int          g_who [4];
   int          g_cyc [4];
   int          n, n_ack1;

   initial begin
      checks = 0; errors = 0; mon_en = 1'b0;
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ack0", 32'(ack0), 32'd0);
      check("rst_ack1", 32'(ack1), 32'd0);
      check("rst_err0", 32'(err0), 32'd0);
      check("rst_err1", 32'(err1), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Store then load, requester 0
      access(0, 1'b1, 7'd8, 32'hDEADBEEF, lat, err, swe);
      check("st8_lat", 32'(lat), 32'd2);
      check("st8_err", 32'(err), 32'd0);
      check("st8_we", 32'(swe), 32'd1);
      check("st8_byte8", 32'(mem[8]), 32'hDE);
      check("st8_byte11", 32'(mem[11]), 32'hEF);
      access(0, 1'b0, 7'd8, 32'd0, lat, err, swe);
      check("ld8_lat", 32'(lat), 32'd2);
      check("ld8_we", 32'(swe), 32'd0);
      check("ld8_rdata", rdata0, 32'hDEADBEEF);

      // Simultaneous requests straight out of reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 7'd4;
      n = 0;
      for (int c = 1; c <= 16 && n < 4; c++) begin
         @(negedge clk);
         if (ack0) begin g_who[n] = 0; g_cyc[n] = c; n++; end
         if (ack1 && n < 4) begin g_who[n] = 1; g_cyc[n] = c; n++; end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("rr_count", 32'(n), 32'd4);
      for (int k = 0; k < n; k++) begin
         check("rr_who", 32'(g_who[k]), 32'(k % 2));
         check("rr_cyc", 32'(g_cyc[k]), 32'(2 + 3 * k));
      end
      check("rr_rdata0", rdata0, 32'h00010203);
      check("rr_rdata1", rdata1, 32'h04050607);

      // Out-of-range accesses from requester 1
      access(1, 1'b1, 7'd125, 32'h11223344, lat, err, swe);
      check("oor_st_lat", 32'(lat), 32'd2);
      check("oor_st_err", 32'(err), 32'd1);
      check("oor_st_we", 32'(swe), 32'd0);
      access(1, 1'b0, 7'd126, 32'd0, lat, err, swe);
      check("oor_ld_err", 32'(err), 32'd1);
      check("oor_ld_rdata", rdata1, 32'd0);
      access(1, 1'b0, 7'd124, 32'd0, lat, err, swe);
      check("ld124_err", 32'(err), 32'd0);
      check("ld124_rdata", rdata1, 32'h7C7D7E7F);

      // Unaligned store and overlapping load
      access(0, 1'b1, 7'd5, 32'hA1B2C3D4, lat, err, swe);
      check("st5_err", 32'(err), 32'd0);
      access(0, 1'b0, 7'd4, 32'd0, lat, err, swe);
      check("ld4_rdata", rdata0, 32'h04A1B2C3);

      // Reset during SERVE of a store
      req0 = 1'b1; we0 = 1'b1; addr0 = 7'd0; wdata0 = 32'hFFFFFFFF;
      @(posedge clk);
      #2;
      check("mid_we_before", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_we_after", 32'(mem_we), 32'd0);
      check("mid_addr_after", 32'(mem_addr), 32'd0);
      check("mid_data_after", mem_data, 32'd0);
      @(negedge clk);
      req0 = 1'b0; we0 = 1'b0;
      check("mid_ack0", 32'(ack0), 32'd0);
      check("mid_rdata0", rdata0, 32'd0);
      check("mid_rdata1", rdata1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("mid_mem0", {mem[0], mem[1], mem[2], mem[3]}, 32'h00010203);
      access(0, 1'b0, 7'd0, 32'd0, lat, err, swe);
      check("post_rst_lat", 32'(lat), 32'd2);
      check("post_rst_rdata", rdata0, 32'h00010203);

      // Back-to-back loads from requester 0 alone
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd12;
      n = 0; n_ack1 = 0;
      for (int c = 1; c <= 12 && n < 3; c++) begin
         @(negedge clk);
         if (ack1) n_ack1++;
         if (ack0) begin g_cyc[n] = c; n++; end
      end
      req0 = 1'b0;
      @(negedge clk);
      check("b2b_count", 32'(n), 32'd3);
      for (int k = 0; k < n; k++) check("b2b_cyc", 32'(g_cyc[k]), 32'(2 + 3 * k));
      check("b2b_ack1", 32'(n_ack1), 32'd0);
      check("b2b_rdata", rdata0, 32'h0C0D0E0F);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
